// File: rtl/sd_boot_pkg.sv
// rtl/sd_boot_pkg.sv - state types and controller register map for the SD boot loader
// S_ERROR exists only when SDBOOT_MAGIC_CHECK_EN is defined.
package sd_boot_pkg;

  localparam logic [9:0] SD_REG_BASE      = 10'd512;
  localparam logic [9:0] SD_REG_SECTOR0   = 10'd0;
  localparam logic [9:0] SD_REG_TRIG_READ = 10'd12;
  localparam int         SECTOR_BYTES     = 512;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_GAP,
    S_RD_WAIT,
    S_MEM_WR,
    S_NEXT,
    S_REG_WR,
    S_REG_WAIT,
    S_WAIT_CB,
    S_DONE
`ifdef SDBOOT_MAGIC_CHECK_EN
    , S_ERROR
`endif
  } state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_STROBE,
    R_GAP,
    R_WAIT
  } rd_state_e;

endpackage

// File: rtl/sd_byte_reader.sv
// rtl/sd_byte_reader.sv - one strobe/gap/ready transaction on the SD controller byte port
// Strobes are registered so sd_ready (which drops combinationally on a strobe) never loops back.
module sd_byte_reader
  import sd_boot_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       write_i,
  input  logic [9:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       accept_o,
  output logic       done_o,
  output logic [7:0] data_o,
  output logic [9:0] sd_addr_o,
  output logic [7:0] sd_wdata_o,
  output logic       sd_read_o,
  output logic       sd_write_o,
  input  logic [7:0] sd_rdata_i,
  input  logic       sd_ready_i
);

  rd_state_e  state_q, state_d;
  logic [9:0] addr_q;
  logic [7:0] wdata_q;
  logic       write_q;

  assign accept_o   = (state_q == R_IDLE) && start_i && sd_ready_i;
  assign done_o     = (state_q == R_WAIT) && sd_ready_i;
  assign data_o     = sd_rdata_i;
  assign sd_addr_o  = addr_q;
  assign sd_wdata_o = wdata_q;
  assign sd_read_o  = (state_q == R_STROBE) && !write_q;
  assign sd_write_o = (state_q == R_STROBE) && write_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:   if (accept_o) state_d = R_STROBE;
      R_STROBE: state_d = R_GAP;
      R_GAP:    state_d = R_WAIT;
      R_WAIT:   if (sd_ready_i) state_d = R_IDLE;
      default:  state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= R_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_o) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        write_q <= write_i;
      end
    end
  end

endmodule

// File: rtl/sd_boot_loader.sv
// rtl/sd_boot_loader.sv - copies boot sectors from the SD controller buffer into main memory
// Optional first-word magic check: SDBOOT_MAGIC_CHECK_EN.
module sd_boot_loader
  import sd_boot_pkg::*;
#(
  parameter logic [31:0] LOAD_ADDR   = 32'h0000_0000,
  parameter int unsigned NUM_SECTORS = 1,
  parameter logic [31:0] BOOT_MAGIC  = 32'h3255_5043
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_boot_ready,
  output logic [9:0]  sd_addr,
  output logic [7:0]  sd_wdata,
  input  logic [7:0]  sd_rdata,
  output logic        sd_read,
  output logic        sd_write,
  input  logic        sd_ready,
  input  logic        sd_callback,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        cpu_reset,
  output logic        boot_done,
  output logic        boot_error
);

  localparam logic [15:0] SECTOR_COUNT = 16'(NUM_SECTORS);

  state_e      state_q, state_d;
  logic [8:0]  byte_idx_q, byte_idx_d;
  logic [15:0] sector_idx_q, sector_idx_d;
  logic [31:0] word_addr_q, word_addr_d;
  logic [31:0] word_buf_q, word_buf_d;
  logic [2:0]  reg_step_q, reg_step_d;

  logic        rd_start, rd_write, rd_accept, rd_done;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_wdata, rd_data;

  sd_byte_reader u_reader (
    .clk        (clk),
    .reset      (reset),
    .start_i    (rd_start),
    .write_i    (rd_write),
    .addr_i     (rd_addr),
    .wdata_i    (rd_wdata),
    .accept_o   (rd_accept),
    .done_o     (rd_done),
    .data_o     (rd_data),
    .sd_addr_o  (sd_addr),
    .sd_wdata_o (sd_wdata),
    .sd_read_o  (sd_read),
    .sd_write_o (sd_write),
    .sd_rdata_i (sd_rdata),
    .sd_ready_i (sd_ready)
  );

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    sector_idx_d = sector_idx_q;
    word_addr_d  = word_addr_q;
    word_buf_d   = word_buf_q;
    reg_step_d   = reg_step_q;
    rd_start     = 1'b0;
    rd_write     = 1'b0;
    rd_addr      = {1'b0, byte_idx_q};
    rd_wdata     = 8'd0;
    case (state_q)
      S_IDLE: if (sd_boot_ready) begin
        byte_idx_d   = '0;
        sector_idx_d = '0;
        word_addr_d  = LOAD_ADDR;
        state_d      = S_RD_REQ;
      end
      S_RD_REQ: begin
        rd_start = 1'b1;
        if (rd_accept) state_d = S_RD_GAP;
      end
      S_RD_GAP: state_d = S_RD_WAIT;
      S_RD_WAIT: if (rd_done) begin
        word_buf_d[{byte_idx_q[1:0], 3'b000} +: 8] = rd_data;
        if (byte_idx_q[1:0] == 2'd3) begin
`ifdef SDBOOT_MAGIC_CHECK_EN
          if (word_addr_q == LOAD_ADDR && word_buf_d != BOOT_MAGIC) state_d = S_ERROR;
          else state_d = S_MEM_WR;
`else
          state_d = S_MEM_WR;
`endif
        end else begin
          byte_idx_d = byte_idx_q + 9'd1;
          state_d    = S_RD_REQ;
        end
      end
      S_MEM_WR: if (mem_ack) begin
        word_addr_d = word_addr_q + 32'd4;
        byte_idx_d  = byte_idx_q + 9'd1;
        if (byte_idx_q == 9'(SECTOR_BYTES - 1)) begin
          sector_idx_d = sector_idx_q + 16'd1;
          state_d      = S_NEXT;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_NEXT: begin
        reg_step_d = '0;
        state_d    = (sector_idx_q == SECTOR_COUNT) ? S_DONE : S_REG_WR;
      end
      // Steps 0..3 load the sector number LSB first, step 4 fires the read trigger.
      S_REG_WR: begin
        rd_start = 1'b1;
        rd_write = 1'b1;
        if (reg_step_q == 3'd4) begin
          rd_addr = SD_REG_BASE + SD_REG_TRIG_READ;
        end else begin
          rd_addr = SD_REG_BASE + SD_REG_SECTOR0 + {7'd0, reg_step_q};
          case (reg_step_q)
            3'd0:    rd_wdata = sector_idx_q[7:0];
            3'd1:    rd_wdata = sector_idx_q[15:8];
            default: rd_wdata = 8'd0;
          endcase
        end
        if (rd_accept) state_d = S_REG_WAIT;
      end
      S_REG_WAIT: if (rd_done) begin
        if (reg_step_q == 3'd4) begin
          state_d = S_WAIT_CB;
        end else begin
          reg_step_d = reg_step_q + 3'd1;
          state_d    = S_REG_WR;
        end
      end
      S_WAIT_CB: if (sd_callback) state_d = S_RD_REQ;
      S_DONE:    state_d = S_DONE;
`ifdef SDBOOT_MAGIC_CHECK_EN
      S_ERROR:   state_d = S_ERROR;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= '0;
      sector_idx_q <= '0;
      word_addr_q  <= '0;
      word_buf_q   <= '0;
      reg_step_q   <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      sector_idx_q <= sector_idx_d;
      word_addr_q  <= word_addr_d;
      word_buf_q   <= word_buf_d;
      reg_step_q   <= reg_step_d;
    end
  end

  assign mem_we    = (state_q == S_MEM_WR);
  assign mem_addr  = word_addr_q;
  assign mem_wdata = word_buf_q;
  assign boot_done = (state_q == S_DONE);
  assign cpu_reset = (state_q != S_DONE);

`ifdef SDBOOT_MAGIC_CHECK_EN
  assign boot_error = (state_q == S_ERROR);
`else
  logic unused_magic;
  assign unused_magic = ^BOOT_MAGIC;
  assign boot_error   = 1'b0;
`endif

endmodule
